isp_blc_linearize: RTL and testbench
====================================

Name: isp_blc_linearize

Overview:
- Black level correction and per-channel linearization stage for raw Bayer data.
- Sits directly upstream of the OECF LUT stage and feeds it with the same href/vsync/data stream format.
- Per pixel: subtracts the per-Bayer-channel black level, multiplies by a per-channel linearization gain, rounds, and saturates.
- Tuning values are shadowed and take effect only at frame boundaries.

Parameters:
- BITS, 8, pixel data width.
- BAYER, 0, CFA phase of the first pixel: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR.
- GAIN_BITS, 16, width of the unsigned linearization gain.
- GAIN_FRAC, 12, number of fractional bits in the gain; unity gain is 2^GAIN_FRAC.

Ports:
- pclk  in  1  pixel clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- blc_en  in  1  enables black level subtraction.
- lin_en  in  1  enables gain multiplication.
- r_black, gr_black, gb_black, b_black  in  BITS each  per-channel black level.
- r_gain, gr_gain, gb_gain, b_gain  in  GAIN_BITS each  per-channel gain.
- in_href  in  1  line-valid.
- in_vsync  in  1  frame sync, active high.
- in_data  in  BITS  raw pixel.
- out_href  out  1  in_href delayed by 3 cycles.
- out_vsync  out  1  in_vsync delayed by 3 cycles.
- out_data  out  BITS  corrected pixel; forced to 0 whenever out_href is 0.

Behaviour:
- Reset:
  - All pipeline registers, the parity trackers and the href/vsync delay lines clear to 0.
  - Shadow enables clear to 0; shadow black levels clear to 0; shadow gains clear to 2^GAIN_FRAC.
  - out_href, out_vsync and out_data are 0 immediately on assertion of rst.
  - A reset mid-frame aborts the frame; nothing is resumed after release.
- Shadow registers:
  - On the pclk edge where in_vsync is 1 and was 0 on the previous cycle, copy blc_en, lin_en, all blacks and all gains into the shadows.
  - The datapath uses only the shadows, so mid-frame writes have no effect until the next vsync rising edge.
- Bayer tracking:
  - odd_pix clears when in_href=0 and toggles every cycle in_href=1.
  - odd_line clears while in_vsync=1 and toggles on each in_href falling edge (prev_href=1, in_href=0).
  - Channel = BAYER xor {odd_line, odd_pix}: 0 R, 1 Gr, 2 Gb, 3 B.
- Stage 1 (register):
  - Select the shadow black level and gain for the channel.
  - diff = blc_en ? max(in_data − black, 0) : in_data; width BITS, no wrap, in_data ≤ black yields 0.
  - Register the selected gain, forced to unity when lin_en=0.
- Stage 2 (register):
  - prod = diff × gain, unsigned, width BITS+GAIN_BITS, full precision.
- Stage 3 (register):
  - res = (prod + 2^(GAIN_FRAC−1)) >> GAIN_FRAC, rounding half up.
  - If res > 2^BITS−1, output 2^BITS−1; otherwise output res.
  - Gain 0 yields 0.
- Latency is fixed at 3 cycles whatever the enables, including full bypass, where out_data equals in_data delayed by 3.
- Pipeline registers advance every cycle with no stall or backpressure; values computed during href=0 are masked at the output.
- in_vsync rising while in_href=1 (malformed input): shadows still update on that edge and pixels already in the pipeline finish with the parameters they were selected with.

Decomposition:
- Shared package/header holds:
  - Bayer pattern codes (RGGB=0, GRBG=1, GBRG=2, BGGR=3).
  - Channel codes (R=0, Gr=1, Gb=2, B=3).
  - Default GAIN_FRAC.
  - A unity-gain constant function of GAIN_FRAC.
- One natural sub-module, isp_bayer_phase: odd_pix/odd_line tracking and channel output, shared with the OECF and digital-gain stages.

Test Plan:
- Subtraction: BAYER=0, blc_en=1, lin_en=1, r_black=16, r_gain=4096, vsync pulse, then first pixel of line 0 = 100 → out_data=84 with out_href=1 exactly 3 cycles after in_href rises.
- Saturation and clamp: gr_black=16, gr_gain=8192, pixel 1 of line 0 = 200 → out 255; same channel with in 10 → out 0, never a wrapped value.
- Rounding: b_black=0, b_gain=6144 (1.5), lin_en=1, B pixel = 3 → out 5; B pixel = 2 → out 3.
- Frame-boundary shadowing: change r_black from 16 to 32 mid-frame → remaining R pixels still use 16 (in 100 → 84); after the next vsync rising edge, in 100 → 68.
- Bayer phase: BAYER=3, distinct blacks R=1, Gr=2, Gb=3, B=4, constant input 50, two lines of 4 pixels → line0 outputs 46,47,46,47 and line1 outputs 48,49,48,49.
- Bypass and reset: blc_en=lin_en=0 gives out_data equal to in_data at 3-cycle latency; asserting rst mid-line drives out_href, out_vsync and out_data to 0 in the same cycle, with no output until a new href after release.

Source files
------------

// File: rtl/isp_blc_linearize_pkg.sv
// Shared CFA/channel codes and gain helpers for the raw-domain correction stages.
package isp_blc_linearize_pkg;

    typedef enum logic [1:0] {
        BAYER_RGGB = 2'd0,
        BAYER_GRBG = 2'd1,
        BAYER_GBRG = 2'd2,
        BAYER_BGGR = 2'd3
    } bayer_e;

    typedef enum logic [1:0] {
        CH_R  = 2'd0,
        CH_GR = 2'd1,
        CH_GB = 2'd2,
        CH_B  = 2'd3
    } chan_e;

    localparam int GAIN_FRAC_DEF = 12;

    function automatic int unity_gain(input int frac);
        return 1 << frac;
    endfunction

endpackage

// File: rtl/isp_blc_linearize_if.sv
// href/vsync/data pixel stream shared by the raw pipeline stages.
interface isp_blc_linearize_if #(parameter int BITS = 8) ();
    logic            href;
    logic            vsync;
    logic [BITS-1:0] data;

    modport master (output href, vsync, data);
    modport slave  (input  href, vsync, data);
endinterface

// File: rtl/isp_blc_linearize_bayer_phase.sv
// Tracks pixel/line parity within a frame and reports the CFA channel of the current pixel.
module isp_bayer_phase
    import isp_blc_linearize_pkg::*;
#(
    parameter int BAYER = 0
) (
    input  logic  pclk,
    input  logic  rst,
    input  logic  href,
    input  logic  vsync,
    output chan_e chan
);

    logic odd_pix, odd_line, prev_href;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            odd_pix   <= 1'b0;
            odd_line  <= 1'b0;
            prev_href <= 1'b0;
        end else begin
            prev_href <= href;
            odd_pix   <= href ? ~odd_pix : 1'b0;
            // vsync restarts the line count; otherwise advance on each line end
            if (vsync)
                odd_line <= 1'b0;
            else if (prev_href && !href)
                odd_line <= ~odd_line;
        end
    end

    assign chan = chan_e'(2'(BAYER) ^ {odd_line, odd_pix});

endmodule

// File: rtl/isp_blc_linearize.sv
// Black level subtraction plus per-channel linear gain with rounding and saturation.
// Fixed 3-cycle latency; tuning is shadowed and latched on the vsync rising edge.
module isp_blc_linearize
    import isp_blc_linearize_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int BAYER     = BAYER_RGGB,
    parameter int GAIN_BITS = 16,
    parameter int GAIN_FRAC = GAIN_FRAC_DEF
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 blc_en,
    input  logic                 lin_en,
    input  logic [BITS-1:0]      r_black,
    input  logic [BITS-1:0]      gr_black,
    input  logic [BITS-1:0]      gb_black,
    input  logic [BITS-1:0]      b_black,
    input  logic [GAIN_BITS-1:0] r_gain,
    input  logic [GAIN_BITS-1:0] gr_gain,
    input  logic [GAIN_BITS-1:0] gb_gain,
    input  logic [GAIN_BITS-1:0] b_gain,
    isp_blc_linearize_if.slave   in_s,
    isp_blc_linearize_if.master  out_s
);

    localparam int STAGES = 3;
    localparam int PW     = BITS + GAIN_BITS;
    localparam logic [GAIN_BITS-1:0] UNITY = GAIN_BITS'(unity_gain(GAIN_FRAC));
    localparam logic [PW:0]          HALF  = (PW+1)'(unity_gain(GAIN_FRAC - 1));

    logic                           vs_prev, vs_rise;
    logic                           blc_en_s, lin_en_s;
    logic [3:0][BITS-1:0]           blk_s;
    logic [3:0][GAIN_BITS-1:0]      gain_s;
    chan_e                          chan;

    logic [BITS-1:0]                blk_c, diff_c;
    logic [PW:0]                    rsum_c, rsh_c;
    logic [BITS-1:0]                sat_c;

    logic [BITS-1:0]                s1_diff;
    logic [GAIN_BITS-1:0]           s1_gain;
    logic [PW-1:0]                  s2_prod;
    logic [BITS-1:0]                s3_data;
    logic [STAGES:1]                vld_pipe, vs_pipe;

    assign vs_rise = in_s.vsync & ~vs_prev;

    // Shadow set indexed by chan_e code: 0 R, 1 Gr, 2 Gb, 3 B
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vs_prev  <= 1'b0;
            blc_en_s <= 1'b0;
            lin_en_s <= 1'b0;
            blk_s    <= '0;
            gain_s   <= {4{UNITY}};
        end else begin
            vs_prev <= in_s.vsync;
            if (vs_rise) begin
                blc_en_s <= blc_en;
                lin_en_s <= lin_en;
                blk_s    <= {b_black, gb_black, gr_black, r_black};
                gain_s   <= {b_gain, gb_gain, gr_gain, r_gain};
            end
        end
    end

    isp_bayer_phase #(.BAYER(BAYER)) u_phase (
        .pclk  (pclk),
        .rst   (rst),
        .href  (in_s.href),
        .vsync (in_s.vsync),
        .chan  (chan)
    );

    always_comb begin
        blk_c  = blk_s[chan];
        diff_c = in_s.data;
        if (blc_en_s)
            diff_c = (in_s.data > blk_c) ? in_s.data - blk_c : '0;
    end

    // Round half up, then clamp anything that overflowed the pixel width
    always_comb begin
        rsum_c = {1'b0, s2_prod} + HALF;
        rsh_c  = rsum_c >> GAIN_FRAC;
        sat_c  = (|rsh_c[PW:BITS]) ? {BITS{1'b1}} : rsh_c[BITS-1:0];
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            s1_diff  <= '0;
            s1_gain  <= '0;
            s2_prod  <= '0;
            s3_data  <= '0;
            vld_pipe <= '0;
            vs_pipe  <= '0;
        end else begin
            s1_diff  <= diff_c;
            s1_gain  <= lin_en_s ? gain_s[chan] : UNITY;
            s2_prod  <= s1_diff * s1_gain;
            s3_data  <= sat_c;
            vld_pipe <= {vld_pipe[STAGES-1:1], in_s.href};
            vs_pipe  <= {vs_pipe[STAGES-1:1], in_s.vsync};
        end
    end

    assign out_s.href  = vld_pipe[STAGES];
    assign out_s.vsync = vs_pipe[STAGES];
    assign out_s.data  = vld_pipe[STAGES] ? s3_data : '0;

endmodule

// File: tb/tb_isp_blc_linearize.sv
// Scoreboard bench: directed pixels push hand-computed results, a negedge monitor pops and compares.
module tb_isp_blc_linearize;

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } exp_t;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        blc_en, lin_en;
    logic [7:0]  r_black, gr_black, gb_black, b_black;
    logic [15:0] r_gain, gr_gain, gb_gain, b_gain;

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t q0[$];
    exp_t q3[$];

    isp_blc_linearize_if #(.BITS(8)) i0 ();
    isp_blc_linearize_if #(.BITS(8)) o0 ();
    isp_blc_linearize_if #(.BITS(8)) i3 ();
    isp_blc_linearize_if #(.BITS(8)) o3 ();

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    isp_blc_linearize #(.BITS(8), .BAYER(0), .GAIN_BITS(16), .GAIN_FRAC(12)) dut0 (
        .pclk(pclk), .rst(rst), .blc_en(blc_en), .lin_en(lin_en),
        .r_black(r_black), .gr_black(gr_black), .gb_black(gb_black), .b_black(b_black),
        .r_gain(r_gain), .gr_gain(gr_gain), .gb_gain(gb_gain), .b_gain(b_gain),
        .in_s(i0), .out_s(o0)
    );

    isp_blc_linearize #(.BITS(8), .BAYER(3), .GAIN_BITS(16), .GAIN_FRAC(12)) dut3 (
        .pclk(pclk), .rst(rst), .blc_en(blc_en), .lin_en(lin_en),
        .r_black(r_black), .gr_black(gr_black), .gb_black(gb_black), .b_black(b_black),
        .r_gain(r_gain), .gr_gain(gr_gain), .gb_gain(gb_gain), .b_gain(b_gain),
        .in_s(i3), .out_s(o3)
    );

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    endtask

    task automatic mon(input int id, input logic h, input logic [7:0] d);
        exp_t  e;
        int    sz;
        string nm;
        nm = (id == 0) ? "dut0" : "dut3";
        sz = (id == 0) ? q0.size() : q3.size();
        if (!h)
            chk({nm, "_mask"}, int'(d), 0);
        else if (sz == 0)
            chk({nm, "_unexpected_href"}, 1, 0);
        else begin
            if (id == 0) e = q0.pop_front();
            else         e = q3.pop_front();
            chk({nm, "_pix"}, int'(d), int'(e.d));
            chk({nm, "_latency"}, cyc - e.cyc, 3);
        end
    endtask

    always @(negedge pclk) begin
        mon(0, o0.href, o0.data);
        mon(3, o3.href, o3.data);
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic pix(input int id, input int d, input int e);
        exp_t x;
        tick();
        x.d   = 8'(e);
        x.cyc = cyc;
        if (id == 0) begin
            i0.href = 1'b1; i0.data = 8'(d); q0.push_back(x);
        end else begin
            i3.href = 1'b1; i3.data = 8'(d); q3.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            i0.href = 1'b0; i0.data = '0;
            i3.href = 1'b0; i3.data = '0;
        end
    endtask

    // vsync pulse; also checks out_vsync appears exactly 3 cycles later
    task automatic frame(input int id);
        tick();
        if (id == 0) i0.vsync = 1'b1; else i3.vsync = 1'b1;
        tick();
        i0.vsync = 1'b0; i3.vsync = 1'b0;
        tick();
        chk("vsync_early", int'(id == 0 ? o0.vsync : o3.vsync), 0);
        tick();
        chk("vsync_lat3", int'(id == 0 ? o0.vsync : o3.vsync), 1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i0.href = 0; i0.vsync = 0; i0.data = 0;
        i3.href = 0; i3.vsync = 0; i3.data = 0;
        blc_en = 1; lin_en = 1;
        r_black = 16; gr_black = 16; gb_black = 0; b_black = 0;
        r_gain = 4096; gr_gain = 8192; gb_gain = 4096; b_gain = 6144;

        #3;
        chk("rst_href",  int'(o0.href),  0);
        chk("rst_vsync", int'(o0.vsync), 0);
        chk("rst_data",  int'(o0.data),  0);
        repeat (2) tick();
        rst = 1'b0;
        idle(3);

        // subtraction, saturation, clamp, rounding
        frame(0);
        pix(0, 100, 84); pix(0, 200, 255); pix(0, 100, 84); pix(0, 10, 0);
        idle(2);
        pix(0, 77, 77); pix(0, 3, 5); pix(0, 0, 0); pix(0, 2, 3);
        idle(2);

        // mid-frame writes stay invisible until the next vsync
        r_black = 32; gr_gain = 0;
        pix(0, 100, 84); pix(0, 200, 255);
        idle(3);
        frame(0);
        pix(0, 100, 68); pix(0, 200, 0);
        idle(2);

        // full bypass
        blc_en = 0; lin_en = 0;
        frame(0);
        pix(0, 5, 5); pix(0, 200, 200); pix(0, 255, 255); pix(0, 0, 0);
        idle(3);

        // reset mid-line while href and vsync are both active at the output
        pix(0, 11, 11);
        i0.vsync = 1'b1;
        pix(0, 22, 22); pix(0, 33, 33); pix(0, 44, 44);
        tick();
        chk("pre_rst_href",  int'(o0.href),  1);
        chk("pre_rst_vsync", int'(o0.vsync), 1);
        rst = 1'b1;
        i0.href = 0; i0.vsync = 0; i0.data = 0;
        q0.delete();
        #1;
        chk("rst_mid_href",  int'(o0.href),  0);
        chk("rst_mid_vsync", int'(o0.vsync), 0);
        chk("rst_mid_data",  int'(o0.data),  0);
        tick(); tick();
        rst = 1'b0;
        // enables asserted but no vsync yet: shadows must still be the reset bypass set
        blc_en = 1; lin_en = 1;
        idle(5);
        pix(0, 7, 7); pix(0, 250, 250);
        idle(3);

        // CFA phase on the BGGR instance
        r_black = 1; gr_black = 2; gb_black = 3; b_black = 4;
        r_gain = 4096; gr_gain = 4096; gb_gain = 4096; b_gain = 4096;
        frame(1);
        pix(1, 50, 46); pix(1, 50, 47); pix(1, 50, 46); pix(1, 50, 47);
        idle(2);
        pix(1, 50, 48); pix(1, 50, 49); pix(1, 50, 48); pix(1, 50, 49);
        idle(6);

        chk("dut0_drained", q0.size(), 0);
        chk("dut3_drained", q3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
